read_bram: RTL and testbench

Streams data out of a block RAM to a downstream module: it issues block-RAM reads over a configured address window, buffers the returned words in a small FIFO and forwards them over the valid/avail stream interface used between pipeline modules. It is the source-side counterpart of the block-RAM writer and sits at the head of a processing chain. It is configured once per run with an iteration count, reads-per-iteration and a base address.

---
 rtl/read_bram_if.sv | 30 +++
 rtl/read_bram.sv | 162 ++++++++++++++++
 tb/tb_read_bram.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_bram_if.sv
// Block-RAM reader bus: configuration, memory read port and output stream.
// master is the reader; slave is the surrounding logic (config source, memory, downstream).
interface read_bram_if #(
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16
);
  logic                              configure;
  logic [LOG_MAX_ITERS-1:0]          num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter;
  logic [LOG_MAX_ADDRESS-1:0]        base_address;
  logic [LOG_MAX_ADDRESS-1:0]        address_out;
  logic                              read_out;
  logic [DATA_WIDTH-1:0]             data_in;
  logic [DATA_WIDTH-1:0]             data_out;
  logic                              valid_out;
  logic                              avail_in;
  logic                              done_out;

  modport master (
    input  configure, num_iters, num_reads_per_iter, base_address, data_in, avail_in,
    output address_out, read_out, data_out, valid_out, done_out
  );

  modport slave (
    output configure, num_iters, num_reads_per_iter, base_address, data_in, avail_in,
    input  address_out, read_out, data_out, valid_out, done_out
  );
endinterface

// File: rtl/read_bram.sv
// Streams an address window of block RAM out through a small credit-checked FIFO.
// Latency: configure -> read 1 cycle, read -> valid_out 2 cycles; done 1 cycle after last transfer.
// Backpressure: avail_in low holds the FIFO; reads stop once FIFO + in-flight fill it. READ_STALL_COUNT_EN adds stall_cycles_out.
module read_bram #(
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16,
  parameter int LOG_FIFO_DEPTH         = 2
) (
  input  logic         clk,
  input  logic         rst,
  read_bram_if.master  bus
`ifdef READ_STALL_COUNT_EN
  ,
  output logic [15:0]  stall_cycles_out
`endif
);
  localparam int DEPTH = 1 << LOG_FIFO_DEPTH;
  localparam int CW    = LOG_FIFO_DEPTH + 1;
  localparam logic [LOG_FIFO_DEPTH-1:0]         PTR_ONE  = LOG_FIFO_DEPTH'(1);
  localparam logic [LOG_MAX_ADDRESS-1:0]        ADDR_ONE = LOG_MAX_ADDRESS'(1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] RD_ONE   = LOG_MAX_READS_PER_ITER'(1);
  localparam logic [LOG_MAX_ITERS-1:0]          IT_ONE   = LOG_MAX_ITERS'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                            state_q, state_d;
  logic [LOG_MAX_ITERS-1:0]          iters_q;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_q;
  logic [LOG_MAX_ADDRESS-1:0]        base_q;
  logic [LOG_MAX_ADDRESS-1:0]        addr_q, addr_d;
  logic [LOG_MAX_READS_PER_ITER-1:0] rd_q, rd_d;
  logic [LOG_MAX_ITERS-1:0]          iter_q, iter_d;
  logic                              read_q, inflight_q, done_q, done_d;
  logic [LOG_MAX_ADDRESS-1:0]        raddr_q;

  logic [DATA_WIDTH-1:0]     fifo_mem [DEPTH];
  logic [LOG_FIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q;

  logic                              accept, issue, push, pop, space_ok, last_rd;
  logic [LOG_MAX_ITERS-1:0]          cur_iters, cur_iter;
  logic [LOG_MAX_READS_PER_ITER-1:0] cur_reads, cur_rd;
  logic [LOG_MAX_ADDRESS-1:0]        cur_base, cur_addr;
  logic [CW:0]                       occupancy;

  // done_q blocks a configure in the done cycle so the next run starts two cycles after the last transfer
  assign accept = (state_q == IDLE) && bus.configure && !done_q;
  assign push   = inflight_q;
  assign pop    = (count_q != '0) && bus.avail_in;

  assign cur_iters = accept ? bus.num_iters          : iters_q;
  assign cur_reads = accept ? bus.num_reads_per_iter : reads_q;
  assign cur_base  = accept ? bus.base_address       : base_q;
  assign cur_addr  = accept ? bus.base_address       : addr_q;
  assign cur_rd    = accept ? '0                     : rd_q;
  assign cur_iter  = accept ? '0                     : iter_q;

  // A read issued now lands two edges later; both older reads still owe a FIFO slot
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) + (CW+1)'(read_q);
  assign space_ok  = occupancy < (CW+1)'(DEPTH);
  assign last_rd   = (cur_rd == cur_reads - RD_ONE);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    addr_d  = cur_addr;
    rd_d    = cur_rd;
    iter_d  = cur_iter;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.num_iters == '0 || bus.num_reads_per_iter == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = READ;
            issue   = 1'b1;
          end
        end
      end
      READ:  issue = space_ok;
      DRAIN: begin
        if (!read_q && !inflight_q && (count_q == '0 || (count_q == CW'(1) && pop))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (last_rd) begin
        rd_d   = '0;
        addr_d = cur_base;
        iter_d = cur_iter + IT_ONE;
        if (cur_iter == cur_iters - IT_ONE) state_d = DRAIN;
      end else begin
        rd_d   = cur_rd + RD_ONE;
        addr_d = cur_addr + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      iters_q    <= '0;
      reads_q    <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      iter_q     <= '0;
      read_q     <= 1'b0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      if (accept) begin
        iters_q <= bus.num_iters;
        reads_q <= bus.num_reads_per_iter;
        base_q  <= bus.base_address;
      end
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      iter_q     <= iter_d;
      read_q     <= issue;
      if (issue) raddr_q <= cur_addr;
      inflight_q <= read_q;
      done_q     <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q    <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.data_in;
  end

`ifdef READ_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_out <= '0;
    end else if (accept) begin
      stall_cycles_out <= '0;
    end else if (count_q != '0 && !bus.avail_in && stall_cycles_out != 16'hFFFF) begin
      stall_cycles_out <= stall_cycles_out + 16'd1;
    end
  end
`endif

  assign bus.read_out    = read_q;
  assign bus.address_out = raddr_q;
  assign bus.done_out    = done_q;
  assign bus.valid_out   = pop;
  assign bus.data_out    = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_read_bram.sv
// Scoreboarded bench for read_bram: a memory model answers reads, a monitor checks addresses, data and done.
module tb_read_bram;
  localparam int DW = 8, LI = 16, LR = 16, LA = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  read_bram_if #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR),
                 .LOG_MAX_ADDRESS(LA)) bus ();
`ifdef READ_STALL_COUNT_EN
  logic [15:0] stall_cycles_out;
`endif

  read_bram #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR),
              .LOG_MAX_ADDRESS(LA), .LOG_FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef READ_STALL_COUNT_EN
    ,
    .stall_cycles_out(stall_cycles_out)
`endif
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0, cfg_cyc = 0;
  int mode = 0;                       // 0: avail high, 1: random, 2: avail low
  logic [7:0] key = 8'h00;
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  int done_exp = 0, done_seen = 0, done_cyc = -1;
  int first_rd_cyc = -1, first_vld_cyc = -1, rd_seen = 0;
  int pushes = 0, pops = 0, stall_exp = 0;
  logic rd_h1 = 1'b0, rd_h2 = 1'b0;
  logic mr;
  logic [15:0] ma;

  function automatic logic [7:0] memval(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory answers one cycle after each read; junk otherwise so stray pushes show up
  initial begin
    bus.data_in = '0;
    forever begin
      @(negedge clk);
      mr = bus.read_out;
      ma = bus.address_out;
      @(posedge clk);
      #1;
      bus.data_in = mr ? memval(ma) : 8'($urandom);
    end
  end

  initial begin
    bus.avail_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       bus.avail_in = 1'b1;
        1:       bus.avail_in = 1'($urandom);
        default: bus.avail_in = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pushes = pops; rd_h1 = 1'b0; rd_h2 = 1'b0; stall_exp = 0;
    end else begin
      // FIFO holds a word once two cycles have passed since its read
      pushes += int'(rd_h2);
      if (pushes > pops && !bus.avail_in && stall_exp < 65535) stall_exp++;
      if (bus.valid_out) pops++;
      rd_h2 = rd_h1;
      rd_h1 = bus.read_out;
      if (bus.configure) stall_exp = 0;

      if (bus.read_out) begin
        rd_seen++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_addr_q.size() == 0) fail_now("unexpected_read");
        else check("read_addr", 32'(bus.address_out), 32'(exp_addr_q.pop_front()));
      end
      if (bus.valid_out) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        check("valid_needs_avail", 32'(bus.avail_in), 32'd1);
        if (exp_data_q.size() == 0) fail_now("unexpected_word");
        else check("data_out", 32'(bus.data_out), 32'(exp_data_q.pop_front()));
      end
      if (bus.done_out) begin
        done_cyc = cyc;
        done_seen++;
        if (done_exp == 0) fail_now("unexpected_done");
        else done_exp--;
        check("done_words_left", 32'(exp_data_q.size()), 32'd0);
      end
    end
  end

  task automatic run_cfg(input int iters, input int reads, input logic [15:0] base);
    logic [15:0] a;
    for (int i = 0; i < iters; i++)
      for (int r = 0; r < reads; r++) begin
        a = base + 16'(r);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(memval(a));
      end
    done_exp++;
    @(posedge clk);
    #1;
    bus.configure          = 1'b1;
    bus.num_iters          = LI'(iters);
    bus.num_reads_per_iter = LR'(reads);
    bus.base_address       = base;
    cfg_cyc = cyc; first_rd_cyc = -1; first_vld_cyc = -1; rd_seen = 0;
    done_seen = 0; done_cyc = -1;
    @(posedge clk);
    #1;
    bus.configure = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_seen == 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (done_seen == 0) fail_now("done_timeout");
    check("words_left", 32'(exp_data_q.size()), 32'd0);
    check("reads_left", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.configure = 1'b0;
    bus.num_iters = '0;
    bus.num_reads_per_iter = '0;
    bus.base_address = '0;
    #2;
    check("rst_read_out", 32'(bus.read_out), 32'd0);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_done_out", 32'(bus.done_out), 32'd0);
    check("rst_address_out", 32'(bus.address_out), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic: memory returns the address
    key = 8'h00;
    run_cfg(1, 4, 16'h0010);
    wait_done(50);
    check("basic_first_read_cyc", 32'(first_rd_cyc - cfg_cyc), 32'd1);
    check("basic_first_valid_cyc", 32'(first_vld_cyc - cfg_cyc), 32'd3);
    check("basic_done_cyc", 32'(done_cyc - cfg_cyc), 32'd7);
    check("basic_reads", 32'(rd_seen), 32'd4);

    // Address wrap across iterations
    key = 8'h5A;
    run_cfg(2, 3, 16'hFFFE);
    wait_done(60);
    check("wrap_reads", 32'(rd_seen), 32'd6);

    // Backpressure: downstream stalled for the first 20 cycles
    key = 8'hC3;
    mode = 2;
    @(posedge clk);
    run_cfg(1, 16, 16'($urandom));
    while (cyc < cfg_cyc + 19) @(negedge clk);
    check("bp_reads_before_stall", 32'(rd_seen), 32'd4);
    mode = 0;
    wait_done(200);
    check("bp_reads_total", 32'(rd_seen), 32'd16);
`ifdef READ_STALL_COUNT_EN
    check("stall_count", 32'(stall_cycles_out), 32'(stall_exp));
`endif

    // Degenerate: zero iterations
    run_cfg(0, 5, 16'h1234);
    wait_done(20);
    check("degen_reads", 32'(rd_seen), 32'd0);
    check("degen_done_cyc", 32'(done_cyc - cfg_cyc), 32'd2);
`ifdef READ_STALL_COUNT_EN
    check("stall_cleared", 32'(stall_cycles_out), 32'd0);
`endif
    run_cfg(4, 0, 16'h0100);
    wait_done(20);
    check("zero_reads_reads", 32'(rd_seen), 32'd0);

    // Reset in the middle of a run
    key = 8'h77;
    run_cfg(1, 10, 16'h0200);
    begin
      int t = 0;
      while (rd_seen < 3 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (rd_seen < 3) fail_now("reset_wait_timeout");
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    done_exp = 0;
    #1;
    check("mid_rst_read_out", 32'(bus.read_out), 32'd0);
    check("mid_rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("mid_rst_done_out", 32'(bus.done_out), 32'd0);
    check("mid_rst_address_out", 32'(bus.address_out), 32'd0);
    check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    key = 8'h3C;
    run_cfg(2, 5, 16'h0400);
    wait_done(100);
    check("post_rst_reads", 32'(rd_seen), 32'd10);

    // Randomised runs with random downstream availability
    mode = 1;
    for (int k = 0; k < 8; k++) begin
      key = 8'($urandom);
      run_cfg(int'($urandom_range(1, 3)), int'($urandom_range(1, 9)), 16'($urandom));
      wait_done(600);
    end
    mode = 0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
